sprite_rom_arbiter: RTL
=======================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the requester count (0 pacman, 1 blinky, 2 pinky, 3 text/scoreboard).
REQ-002 Parameter ADDR_W, default 17, SHALL set the shared sprite ROM word-address width.
REQ-003 Parameter DATA_W, default 4, SHALL set the palette-index width per ROM word.
REQ-004 Parameter ROM_LAT, default 2, SHALL set the fixed ROM read latency in cycles (rom_en to rom_data).
REQ-005 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 req  input  NUM_REQ  SHALL carry per-requester read requests, held until granted.
REQ-008 req_addr  input  NUM_REQ*ADDR_W  SHALL carry per-requester addresses, slice i for requester i.
REQ-009 frame_start  input  1  SHALL be a one-cycle pulse at start of frame (DrawX=0, DrawY=0).
REQ-010 gnt  output  NUM_REQ  SHALL be a one-hot grant, combinational from req and pointer.
REQ-011 rom_en  output  1  SHALL be the registered ROM read strobe.
REQ-012 rom_addr  output  ADDR_W  SHALL be the registered ROM address.
REQ-013 rom_data  input  DATA_W  SHALL be ROM read data, valid ROM_LAT cycles after rom_en.
REQ-014 rsp_valid  output  NUM_REQ  SHALL be a one-hot registered response strobe naming the owning requester.
REQ-015 rsp_data  output  DATA_W  SHALL be the registered palette index returned with rsp_valid.
REQ-016 busy  output  1  SHALL be high while any read is in flight (rom_en issued, rsp not yet delivered).

Function
REQ-017 At most one gnt bit SHALL be high per cycle; gnt SHALL be zero when req is zero.
REQ-018 Grant SHALL be round-robin: search starts at pointer ptr, first set req bit at index ptr, ptr+1, ... wrapping mod NUM_REQ wins.
REQ-019 On a grant to index k, ptr SHALL become (k+1) mod NUM_REQ next cycle; with no grant ptr SHALL hold.
REQ-020 frame_start SHALL force ptr to 0 next cycle, overriding REQ-019; a grant in that same cycle SHALL still be issued and serviced.
REQ-021 Grant in cycle t SHALL produce rom_en=1 and rom_addr=req_addr slice k in cycle t+1; no grant SHALL produce rom_en=0 with rom_addr holding.
REQ-022 A tag pipeline of depth ROM_LAT+1 SHALL carry the one-hot owner; rsp_valid SHALL assert in cycle t+2+ROM_LAT (t+4 at default) with rsp_data = rom_data sampled at t+1+ROM_LAT.
REQ-023 Throughput SHALL be one grant per cycle; back-to-back grants SHALL produce back-to-back responses in grant order.
REQ-024 A requester dropping req before grant SHALL receive no grant and no response; no request is queued internally.
REQ-025 A continuously requesting requester SHALL be granted within NUM_REQ cycles (starvation bound).
REQ-026 rsp_data SHALL hold its last value when rsp_valid is zero.

Reset
REQ-027 Reset_n low SHALL asynchronously clear ptr to 0, rom_en to 0, rom_addr to 0, tag pipeline to 0, rsp_valid to 0, rsp_data to 0, busy to 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight reads; no rsp_valid SHALL appear for them after release.
REQ-029 gnt SHALL be zero while Reset_n is low regardless of req.

Structure
REQ-030 NUM_REQ, ADDR_W, DATA_W, ROM_LAT defaults and a requester-index enum (REQ_PACMAN, REQ_BLINKY, REQ_PINKY, REQ_TEXT) SHALL live in shared package sprite_pkg.
REQ-031 The round-robin grant logic and ptr register SHALL be one sub-module rr_arbiter (inputs req, frame_start; output gnt).
REQ-032 The ROM itself SHALL be external; this block SHALL contain no sprite storage.

Verification
REQ-033 Reset release, req=4'b0001, req_addr[0]=17'h00120 -> gnt=0001 at t, rom_en=1/rom_addr=00120 at t+1, rsp_valid=0001 at t+4 with model ROM data.
REQ-034 req=4'b1111 held 8 cycles from ptr=0 -> gnt sequence 0001,0010,0100,1000,0001,... and eight responses in identical order.
REQ-035 ptr=2, req=4'b0011 -> gnt=0001 (wrap), next ptr=1; then req=4'b0011 -> gnt=0010.
REQ-036 frame_start with req=4'b1000 at ptr=1 -> gnt=1000 serviced, next-cycle ptr=0, req=4'b1001 -> gnt=0001.
REQ-037 Three grants in flight then Reset_n pulsed low 1 cycle -> all outputs 0 immediately, no rsp_valid for 10 cycles after release.
REQ-038 req[2] asserted then dropped before grant while req[0] granted -> no gnt[2], no rsp_valid[2].

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite ROM arbiter definitions: parameter defaults and requester indices.
package sprite_pkg;

   localparam int NUM_REQ_DEF = 4;
   localparam int ADDR_W_DEF  = 17;
   localparam int DATA_W_DEF  = 4;
   localparam int ROM_LAT_DEF = 2;

   // Fixed requester slots on the shared sprite ROM.
   typedef enum logic [1:0] {
      REQ_PACMAN = 2'd0,
      REQ_BLINKY = 2'd1,
      REQ_PINKY  = 2'd2,
      REQ_TEXT   = 2'd3
   } req_idx_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer,
// pointer forced to requester 0 at the start of every frame.
module rr_arbiter
   import sprite_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               frame_start,
   output logic [NUM_REQ-1:0] gnt
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(NUM_REQ);

   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   ptr_next;
   logic [PTR_W:0]     sum;
   logic [PTR_W-1:0]   idx;
   logic               found;
   logic [NUM_REQ-1:0] gnt_raw;

   // Search req starting at ptr, wrapping modulo NUM_REQ; first set bit wins.
   always_comb begin
      gnt_raw = '0;
      found   = 1'b0;
      win_idx = '0;
      sum     = '0;
      idx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sum = {1'b0, ptr} + (PTR_W + 1)'(i);
         if (sum >= N_EXT) sum = sum - N_EXT;
         idx = sum[PTR_W-1:0];
         if (!found && req[idx]) begin
            gnt_raw[idx] = 1'b1;
            win_idx      = idx;
            found        = 1'b1;
         end
      end
   end

   // Pointer moves to the slot after the winner, wrapping at NUM_REQ.
   always_comb begin
      if ({1'b0, win_idx} == N_EXT - 1'b1) ptr_next = '0;
      else                                  ptr_next = win_idx + 1'b1;
   end

   // Grant is masked while reset is held so no request leaks through.
   always_comb begin
      gnt = Reset_n ? gnt_raw : '0;
   end

   // Pointer register: frame start wins over the normal post-grant update.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)         ptr <= '0;
      else if (frame_start) ptr <= '0;
      else if (found)       ptr <= ptr_next;
   end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one external sprite ROM among the game requesters. A grant issues
// a registered ROM read next cycle; a one-hot owner tag rides alongside the
// ROM latency so the returned palette index is routed back to its requester.
//
// Handshake: req[i] is a held request; the read is accepted in the cycle
// where req[i] & gnt[i]. A requester that drops req before that cycle is
// simply never served (nothing is queued). rsp_valid has no back-pressure:
// the owner must take rsp_data in the cycle rsp_valid names it.
module sprite_rom_arbiter
   import sprite_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ROM_LAT = ROM_LAT_DEF
) (
   input  logic                      Clk,
   input  logic                      Reset_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic                      frame_start,
   output logic [NUM_REQ-1:0]        gnt,
   output logic                      rom_en,
   output logic [ADDR_W-1:0]         rom_addr,
   input  logic [DATA_W-1:0]         rom_data,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      busy
);

   logic [ADDR_W-1:0]  sel_addr;
   logic [NUM_REQ-1:0] tag_q [ROM_LAT+1];

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
      .req         (req),
      .frame_start (frame_start),
      .gnt         (gnt)
   );

   // Address of the granted requester (gnt is one-hot).
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
   end

   // ROM strobe/address, owner tag pipeline and response register.
   // tag_q[ROM_LAT] lines up with the cycle rom_data is valid.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rom_en    <= 1'b0;
         rom_addr  <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         for (int j = 0; j <= ROM_LAT; j++) tag_q[j] <= '0;
      end else begin
         rom_en <= |gnt;
         if (|gnt) rom_addr <= sel_addr;
         tag_q[0] <= gnt;
         for (int j = 1; j <= ROM_LAT; j++) tag_q[j] <= tag_q[j-1];
         rsp_valid <= tag_q[ROM_LAT];
         if (|tag_q[ROM_LAT]) rsp_data <= rom_data;
      end
   end

   // Busy while any owner tag is still travelling toward rsp_valid.
   always_comb begin
      busy = 1'b0;
      for (int j = 0; j <= ROM_LAT; j++) busy = busy | (|tag_q[j]);
   end

endmodule
